// File: rtl/game_2048_pkg.sv
// Shared types, constants and helpers for the 2048 game core datapath.
package game_2048_pkg;

  localparam int EXP_W = 4;
  localparam int CELLS = 16;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_SPAWN,
    S_DONE
  } state_e;

  localparam logic [15:0] SCORE_SAT_BIN = 16'hFFFF;
  localparam logic [15:0] SCORE_SAT_BCD = 16'h9999;
  localparam logic [63:0] BOARD_INIT    = 64'h0000_0000_0010_0001;

  // Board cell visited at position pos (0 = destination edge) of a line.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    case (dir)
      DIR_UP:   cell_idx = {pos, line};
      DIR_DOWN: cell_idx = {~pos, line};
      DIR_LEFT: cell_idx = {line, pos};
      default:  cell_idx = {line, ~pos};
    endcase
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational 2048 line merge: compress toward k=0, merge equal pairs once.
module line_merge
  import game_2048_pkg::*;
(
  input  logic [15:0] line_in,
  output logic [15:0] line_out,
  output logic        changed,
  output logic [16:0] score_add
);

  logic [19:0] comp;
  logic [1:0]  n;
  logic [1:0]  m;
  logic        skip;

  always_comb begin
    comp      = '0;
    line_out  = '0;
    score_add = '0;
    n         = '0;
    m         = '0;
    skip      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (line_in[4*k +: 4] != 4'd0) begin
        comp[{n, 2'b00} +: 4] = line_in[4*k +: 4];
        n = n + 2'd1;
      end
    end
    // comp[19:16] stays zero so the look-ahead at k=3 never matches.
    for (int k = 0; k < 4; k++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[4*k +: 4] != 4'd0) begin
        if (comp[4*k +: 4] == comp[4*k+4 +: 4] && comp[4*k +: 4] != 4'hF) begin
          line_out[{m, 2'b00} +: 4] = comp[4*k +: 4] + 4'd1;
          score_add = score_add + (17'd1 << (comp[4*k +: 4] + 4'd1));
          skip = 1'b1;
        end else begin
          line_out[{m, 2'b00} +: 4] = comp[4*k +: 4];
        end
        m = m + 2'd1;
      end
    end
    changed = (line_out != line_in);
  end

endmodule

// File: rtl/board_move_sequencer.sv
// 2048 move sequencer: one line per cycle through line_merge, then spawn and status.
// Build option SCORE_BCD_EN keeps the score as 4-digit packed BCD saturating at 9999.
module board_move_sequencer
  import game_2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  output logic               move_ready,
  input  logic               load_en,
  input  logic [63:0]        load_board,
  input  logic               new_game,
  output logic               move_done,
  output logic               board_changed,
  output logic [63:0]        board,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  state_e             state_q, state_n;
  logic [63:0]        board_q, board_wr;
  logic [SCORE_W-1:0] score_q;
  logic               game_over_q;
  logic               changed_q;
  logic [1:0]         dir_q;
  logic [1:0]         line_q;
  logic [3:0]         scan_q;
  logic [15:0]        lfsr_q;
  logic               accept;
  logic               spawn_empty;
  logic [3:0]         spawn_val;
  logic [15:0]        line_in, line_out;
  logic               merge_changed;
  logic [16:0]        score_add;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic no_moves(input logic [63:0] b);
    logic dead;
    dead = 1'b1;
    for (int c = 0; c < CELLS; c++) begin
      if (b[4*c +: 4] == 4'd0) dead = 1'b0;
      if ((c % 4) != 3 && b[4*c +: 4] == b[4*c+4 +: 4]) dead = 1'b0;
      if (c < 12 && b[4*c +: 4] == b[4*c+16 +: 4]) dead = 1'b0;
    end
    return dead;
  endfunction

`ifdef SCORE_BCD_EN
  function automatic logic [15:0] bin2bcd(input logic [13:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++)
        if (r[4*j +: 4] >= 4'd5) r[4*j +: 4] = r[4*j +: 4] + 4'd3;
      r = {r[14:0], v[i]};
    end
    return r;
  endfunction

  // Contributions of 10000 or more can only saturate, so skip their conversion.
  function automatic logic [15:0] score_accum(input logic [15:0] s, input logic [16:0] add);
    logic [15:0] a, res;
    logic [4:0]  d;
    logic        c;
    if (add > 17'd9999) return SCORE_SAT_BCD;
    a   = bin2bcd(add[13:0]);
    c   = 1'b0;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, s[4*i +: 4]} + {1'b0, a[4*i +: 4]} + {4'd0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      res[4*i +: 4] = d[3:0];
    end
    return c ? SCORE_SAT_BCD : res;
  endfunction
`else
  function automatic logic [15:0] score_accum(input logic [15:0] s, input logic [16:0] add);
    logic [16:0] sum;
    sum = {1'b0, s} + add;
    return (sum > 17'h0FFFF) ? SCORE_SAT_BIN : sum[15:0];
  endfunction
`endif

  line_merge u_merge (
    .line_in   (line_in),
    .line_out  (line_out),
    .changed   (merge_changed),
    .score_add (score_add)
  );

  always_comb begin
    line_in  = '0;
    board_wr = board_q;
    for (int k = 0; k < 4; k++) begin
      line_in[4*k +: 4] = board_q[{cell_idx(dir_q, line_q, 2'(k)), 2'b00} +: 4];
      board_wr[{cell_idx(dir_q, line_q, 2'(k)), 2'b00} +: 4] = line_out[4*k +: 4];
    end
  end

  assign spawn_empty = (board_q[{scan_q, 2'b00} +: 4] == 4'd0);
  assign spawn_val   = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;

  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!load_en && move_valid && !game_over_q && !new_game) begin
          accept  = 1'b1;
          state_n = S_LINE;
        end
      end
      S_LINE: begin
        if (line_q == 2'd3) state_n = (changed_q | merge_changed) ? S_SPAWN : S_DONE;
      end
      S_SPAWN: begin
        if (spawn_empty) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
    if (new_game) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst)         lfsr_q <= LFSR_SEED;
    else if (accept) lfsr_q <= lfsr_next(lfsr_q);
  end

  // new_game discards any partially written lines along with the score.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      board_q     <= BOARD_INIT;
      score_q     <= '0;
      game_over_q <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_en) begin
            board_q     <= load_board;
            game_over_q <= 1'b0;
          end else if (accept) begin
            dir_q     <= move_dir;
            changed_q <= 1'b0;
            line_q    <= 2'd0;
          end
        end
        S_LINE: begin
          board_q   <= board_wr;
          changed_q <= changed_q | merge_changed;
          score_q   <= score_accum(score_q, score_add);
          line_q    <= line_q + 2'd1;
          if (line_q == 2'd3) scan_q <= lfsr_q[3:0];
        end
        S_SPAWN: begin
          if (spawn_empty) board_q[{scan_q, 2'b00} +: 4] <= spawn_val;
          else             scan_q <= scan_q + 4'd1;
        end
        default: game_over_q <= no_moves(board_q);
      endcase
    end
  end

  assign move_ready    = (state_q == S_IDLE) & ~game_over_q;
  assign move_done     = (state_q == S_DONE);
  assign board_changed = changed_q;
  assign board         = board_q;
  assign score         = score_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_board_move_sequencer.sv
// Directed bench for board_move_sequencer; expectations follow the SCORE_BCD_EN build setting.
module tb_board_move_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'b00;
  logic        move_ready;
  logic        load_en = 1'b0;
  logic [63:0] load_board = '0;
  logic        new_game = 1'b0;
  logic        move_done;
  logic        board_changed;
  logic [63:0] board;
  logic [15:0] score;
  logic        game_over;

  int total = 0;
  int bad   = 0;
  int lat;
  int extra;

  localparam logic [63:0] INIT_IMG = 64'h0000_0000_0010_0001;

  board_move_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .move_valid    (move_valid),
    .move_dir      (move_dir),
    .move_ready    (move_ready),
    .load_en       (load_en),
    .load_board    (load_board),
    .new_game      (new_game),
    .move_done     (move_done),
    .board_changed (board_changed),
    .board         (board),
    .score         (score),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_nz(input logic [63:0] b);
    int n = 0;
    for (int c = 0; c < 16; c++) if (b[4*c +: 4] != 4'd0) n++;
    return n;
  endfunction

  task automatic pulse_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  task automatic load(input logic [63:0] img);
    @(negedge clk); load_en = 1'b1; load_board = img;
    @(negedge clk); load_en = 1'b0;
    check("load", board, img);
  endtask

  // Returns the cycle (accept = 0) of move_done, or -1; ends at the negedge of the DONE cycle.
  task automatic do_move(input logic [1:0] d, input bit poke, output int l);
    @(negedge clk); move_valid = 1'b1; move_dir = d;
    @(negedge clk); move_valid = 1'b0;
    l = -1;
    for (int k = 1; k <= 40; k++) begin
      if (move_done) begin
        l = k;
        break;
      end
      if (poke && k == 2) begin
        move_valid = 1'b1;
        move_dir   = ~d;
      end else begin
        move_valid = 1'b0;
      end
      @(negedge clk);
    end
    move_valid = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (move_done) n++;
    end
  endtask

  initial begin
    logic [15:0] exp_s1, exp_s2, exp_sat;
`ifdef SCORE_BCD_EN
    exp_s1 = 16'h0032; exp_s2 = 16'h0064; exp_sat = 16'h9999;
`else
    exp_s1 = 16'h0020; exp_s2 = 16'h0040; exp_sat = 16'hFFFF;
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_board", board, INIT_IMG);
    check("rst_score", score, 0);
    check("rst_ready", move_ready, 1);
    check("rst_gameover", game_over, 0);
    check("rst_done", move_done, 0);
    check("rst_changed", board_changed, 0);

    // Row 0 = 1,1,1,1 moved left
    load(64'h0000_0000_0000_1111);
    do_move(2'b10, 1'b0, lat);
    check("left_lat_range", (lat >= 6 && lat <= 21), 1);
    check("left_row0", board[7:0], 8'h22);
    check("left_tiles", count_nz(board), 3);
    check("left_spawn_val", (board[63:8] != 0) &&
          ((board[63:8] & ~(board[63:8] & 56'h33333333333333)) == 0), 1);
    check("left_score", score, 8);
    check("left_changed", board_changed, 1);

    // Row 0 = 2,0,2,0 moved right
    pulse_new_game();
    load(64'h0000_0000_0000_0202);
    do_move(2'b11, 1'b0, lat);
    check("right_lat_range", (lat >= 6 && lat <= 21), 1);
    check("right_cell3", board[15:12], 4'd3);
    check("right_tiles", count_nz(board), 2);
    check("right_score", score, 8);
    check("right_changed", board_changed, 1);

    // 15,15 never merge; a move_valid poke mid-move is ignored
    pulse_new_game();
    load(64'h0000_0000_0000_00FF);
    do_move(2'b10, 1'b1, lat);
    check("exp15_lat", lat, 5);
    check("exp15_board", board, 64'h0000_0000_0000_00FF);
    check("exp15_changed", board_changed, 0);
    check("exp15_score", score, 0);
    count_done(12, extra);
    check("busy_poke_ignored", extra, 0);
    check("exp15_gameover", game_over, 0);

    // Full checkerboard: no legal move
    load(64'h1212_2121_1212_2121);
    do_move(2'b00, 1'b0, lat);
    check("dead_lat", lat, 5);
    check("dead_changed", board_changed, 0);
    @(negedge clk);
    check("dead_gameover", game_over, 1);
    check("dead_ready", move_ready, 0);
    @(negedge clk); move_valid = 1'b1; move_dir = 2'b10;
    count_done(8, extra);
    move_valid = 1'b0;
    check("dead_no_accept", extra, 0);
    pulse_new_game();
    check("ng_board", board, INIT_IMG);
    check("ng_gameover", game_over, 0);
    check("ng_ready", move_ready, 1);

    // new_game while line 2 is being processed
    load(64'h0000_0000_0000_1111);
    @(negedge clk); move_valid = 1'b1; move_dir = 2'b10;
    @(negedge clk); move_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    check("abort_ready", move_ready, 1);
    check("abort_board", board, INIT_IMG);
    check("abort_score", score, 0);
    count_done(25, extra);
    check("abort_no_done", extra, 0);

    // Score format: two preloaded 3,3,3,3 left moves
    load(64'h0000_0000_0000_3333);
    do_move(2'b10, 1'b0, lat);
    check("sc1_row0", board[7:0], 8'h44);
    check("sc1_score", score, exp_s1);
    load(64'h0000_0000_0000_3333);
    do_move(2'b10, 1'b0, lat);
    check("sc2_score", score, exp_s2);

    // Saturation: 14,14,14,14 contributes 65536
    pulse_new_game();
    load(64'h0000_0000_0000_EEEE);
    do_move(2'b10, 1'b0, lat);
    check("sat_row0", board[7:0], 8'hFF);
    check("sat_score", score, exp_sat);
    load(64'h0000_0000_0000_0011);
    do_move(2'b10, 1'b0, lat);
    check("sat_hold", score, exp_sat);
    check("sat_lat_range", (lat >= 6 && lat <= 21), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_move_sequencer.md
Name: board_move_sequencer

Overview:
- Sequences the 2048 board datapath for the game core.
- Holds a 4x4 board of 4-bit tile exponents and accepts one direction command at a time.
- Processes the four lines one per cycle through a combinational merge unit, then spawns a new tile and updates the score and game-over status.
- The board output feeds the VGA tile renderer; the score output drives the seven-segment scan logic.

Parameters:
- LFSR_SEED, 16'hACE1, non-zero seed loaded into the 16-bit spawn LFSR on rst.
- SCORE_W, 16, score width; matches the 4-digit SSD.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- move_valid  in  1  direction command valid
- move_dir  in  2  00 up, 01 down, 10 left, 11 right
- move_ready  out  1  sequencer can accept a command
- load_en  in  1  board preload strobe (test/debug)
- load_board  in  64  preload image; cell c = bits [4c+3:4c]
- new_game  in  1  restart strobe
- move_done  out  1  one-cycle pulse at move completion
- board_changed  out  1  last move altered the board; valid from move_done until the next accept
- board  out  64  current board; exponent 0 = empty, n = tile 2^n
- score  out  SCORE_W  accumulated score
- game_over  out  1  no legal move remains

Behaviour:
- Cell index c = row*4 + col; row 0 is the top row.
- Line i, position k (k=0 is the destination edge):
  - up: cell k*4+i
  - down: (3-k)*4+i
  - left: i*4+k
  - right: i*4+3-k
- Reset / new_game state:
  - board = cell0 = 1, cell5 = 1, all other cells 0.
  - score = 0, game_over = 0, move_done = 0, board_changed = 0.
  - FSM in IDLE.
  - rst reseeds the LFSR; new_game does not.
  - new_game takes effect in any state, aborts a move in progress (partial line writes remain discarded, board reinitialised), and returns to IDLE on the next cycle.
  - rst has priority over new_game.
- FSM states: IDLE, LINE, SPAWN, DONE.
- IDLE:
  - move_ready = ~game_over.
  - A command is accepted on move_valid & move_ready. The accept cycle latches move_dir, clears the changed flag, sets line counter to 0, and advances the LFSR once.
  - load_en is honoured only in IDLE and writes board in one cycle. load_en has priority over move_valid in the same cycle. It does not alter score and clears game_over.
- LINE (exactly 4 cycles, lines 0..3):
  - Each cycle reads the 4 cells of the line, passes them through the merge unit, and writes the result back.
  - OR the line-changed bit into the changed flag.
  - Add the line's score contribution.
  - After line 3: go to SPAWN if changed, else go to DONE.
- Merge rule:
  - Compress non-zero tiles toward k=0.
  - Merge equal adjacent pairs once each, scanning from k=0.
  - Each merged result is e+1, and the score adds 2^(e+1).
  - Exponent 15 tiles never merge.
- Score arithmetic: the sum uses a 17-bit intermediate, and the score saturates at 16'hFFFF.
- SPAWN:
  - On entry, the scan index is LFSR[3:0]. Each cycle, test the cell at the scan index.
  - If the cell is empty, write exponent 2 when LFSR[7:4] == 0, else exponent 1, then go to DONE.
  - Otherwise increment the index mod 16.
  - Takes 1..16 cycles. A changed board always has at least one empty cell.
- DONE (1 cycle):
  - move_done = 1 and board_changed = changed flag.
  - game_over is registered as: no empty cell AND no horizontally or vertically adjacent equal pair.
  - Return to IDLE.
- Latency, with the accept at cycle 0:
  - unchanged move: move_done at cycle 5.
  - changed move: move_done at cycle 6..21.
- move_valid outside IDLE is ignored (no queueing). move_dir is sampled only at accept.

Optional Feature:
- Macro SCORE_BCD_EN.
- Defined: score is held as 4-digit packed BCD. The merge contribution is added with a BCD adder, and the score saturates at 16'h9999, so the SSD shows decimal.
- Undefined: score is binary and saturates at 16'hFFFF.
- Merge, timing and every other behaviour are identical in both builds.

Decomposition:
- Package game_2048_pkg holds:
  - direction encodings DIR_UP/DOWN/LEFT/RIGHT
  - FSM state enum
  - EXP_W = 4, CELLS = 16
  - cell-index function (dir, line, pos)
  - score saturation constants
- Sub-module line_merge (combinational):
  - inputs: 4 x 4-bit cells
  - outputs: 4 x 4-bit merged cells, changed bit, 17-bit score_add

Test Plan:
- Reset: board == 64'h0000_0000_0010_0001, score 0, move_ready 1, game_over 0, move_done 0.
- Load row0 = 1,1,1,1, rest empty; move left -> row0 = 2,2,0,0; score 8; board_changed 1; exactly one new tile of exponent 1 or 2 in a previously empty cell; move_done at cycle 6..21.
- Load row0 = 2,0,2,0; move right -> row0 = 0,0,0,3; score 8. Load row0 = 15,15,0,0; move left -> unchanged; board_changed 0; move_done at exactly cycle 5.
- Load a full board with no equal neighbours (alternating 1/2 checkerboard); move up -> board_changed 0; game_over 1 after move_done; move_ready 0; new_game -> reset board, game_over 0, move_ready 1.
- Assert new_game during LINE cycle 2 -> next cycle state IDLE, board == reset image, score 0, no move_done pulse. Pulse move_valid while not in IDLE -> ignored.
- SCORE_BCD_EN build: load row0 = 3,3,3,3 and move left twice via preloads -> score 16'h0032 after the first move (2 merges of 16 each); binary build gives 16'h0020.
